log_dump_ctrl: RTL and testbench
================================

Name: log_dump_ctrl

Overview:
Sequencer for the sample logger: on host command it arms a capture, waits for the logger's full flag, then sweeps the logger read address and streams every stored I/Q word out on a valid/ready interface. It sits between the host/UART command path and the logger memory. It is the only driver of the logger's run, read and address inputs.

Parameters:
ADDR_W, 15, logger address width
DATA_W, 16, logged word width (I in [15:8], Q in [7:0])
RD_LATENCY, 1, cycles from a stable address to valid logger read data (>=1)
N_WORDS, 2**ADDR_W, words dumped per readout (1..2**ADDR_W)
WDOG_CYCLES, 2**(ADDR_W+1), capture timeout (used only with LOG_WDOG_EN)

Ports:
clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_start  in  1  host pulse: start a new capture
i_dump  in  1  host pulse: start readout of a full memory
i_abort  in  1  host pulse: abort readout
o_run_log  out  1  to logger run input, one-cycle pulse
o_read_log  out  1  to logger read input, one-cycle pulse
o_addr_log_to_mem  out  ADDR_W  to logger read address
i_mem_full  in  1  from logger full flag
i_data_log_from_mem  in  DATA_W  from logger read data
o_data  out  DATA_W  stream data (registered)
o_valid  out  1  stream valid
i_ready  in  1  stream ready
o_last  out  1  high with final word of the dump
o_busy  out  1  high in every state except IDLE, FULL and DONE
o_err  out  1  sticky capture timeout (LOG_WDOG_EN only, else 0)

Behaviour:
- Interface: one clock, clk. Reset i_rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, address counter 0.
- State machine transitions:
  - IDLE: i_start -> ARM.
  - ARM: o_run_log=1 for exactly this cycle -> CAPTURE.
  - CAPTURE: the first cycle is blanking and i_mem_full is ignored. After blanking, i_mem_full=1 -> FULL.
  - FULL: i_dump -> RDREQ. i_start -> ARM.
  - RDREQ: o_read_log=1 for one cycle, address counter cleared -> SETTLE.
  - SETTLE: one cycle while the logger enters its read state -> ADDR.
  - ADDR: o_addr_log_to_mem = counter, held stable. Wait RD_LATENCY cycles, then register i_data_log_from_mem into o_data and enter OUT.
  - OUT: o_valid=1, with o_data, o_last and the address held until i_ready=1. On handshake, if counter==N_WORDS-1 -> DONE, else counter+1 -> ADDR.
  - DONE: i_start -> ARM. i_dump -> RDREQ (re-dump with identical data).
- o_last = (counter==N_WORDS-1) && o_valid.
- Throughput: one word per RD_LATENCY+1 cycles when i_ready is held high.
- Counter width is ADDR_W. No wrap occurs, because the dump ends at N_WORDS-1.
- o_valid never deasserts without a handshake, except on i_abort or reset.
- i_abort in RDREQ, SETTLE, ADDR or OUT: o_valid drops the next cycle, state -> FULL, no o_last. i_abort is ignored in every other state; a running capture cannot be stopped.
- i_start and i_dump are ignored outside the states listed above.
- Simultaneous commands: i_start has priority over i_dump in FULL/DONE. i_abort has priority over a handshake in OUT.
- Reset mid-operation returns to IDLE immediately. Logger state is not guaranteed after a reset, so the host must issue i_start.
- o_run_log and o_read_log are registered and never high together.

Optional Feature:
LOG_WDOG_EN
- Defined: a counter runs in CAPTURE. If i_mem_full is not seen within WDOG_CYCLES cycles, o_err is set and state -> IDLE. o_err clears only on i_rst or on the next i_start.
- Not defined: no counter, CAPTURE waits indefinitely, o_err tied 0.

Decomposition:
- Package log_ctrl_pkg holds:
  - the state encoding typedef (IDLE, ARM, CAPTURE, FULL, RDREQ, SETTLE, ADDR, OUT, DONE);
  - default ADDR_W/DATA_W constants, shared with the logger;
  - the I/Q field position constants.
- One sub-module, log_wdog (timeout counter), is instantiated only under LOG_WDOG_EN.
- The read-latency wait stays inline.

Test Plan:
- ADDR_W=4, N_WORDS=16, RD_LATENCY=1, behavioural logger. i_start -> o_run_log pulse 1 cycle after; FULL reached after i_mem_full; o_busy low in FULL.
- Logger filled with 0x0100+k, i_dump, i_ready=1 -> 16 words 0x0100..0x010F in order, 2 cycles apart; o_last only on 0x010F; DONE.
- Same dump, i_ready toggling 1-0-1 randomly -> o_data/o_addr_log_to_mem stable while stalled; no drops or duplicates; 16 handshakes total.
- i_abort on the 5th OUT (word 0x0104) -> o_valid low next cycle, state FULL. Re-i_dump -> restarts at 0x0100.
- i_start asserted together with i_dump in DONE -> ARM taken, o_read_log stays 0. i_abort in CAPTURE -> ignored.
- LOG_WDOG_EN, WDOG_CYCLES=40, i_mem_full held 0 -> o_err=1 at cycle 40 of CAPTURE, IDLE. Next i_start clears o_err.

Source files
------------

// File: rtl/log_dump_ctrl_pkg.sv
// Shared definitions for the sample logger dump sequencer: state encoding,
// default logger geometry and I/Q field positions in a logged word.
package log_ctrl_pkg;

  // Default logger geometry, shared with the logger itself
  localparam int LOG_ADDR_W = 15;
  localparam int LOG_DATA_W = 16;

  // I/Q packing inside a logged word
  localparam int LOG_I_MSB = 15;
  localparam int LOG_I_LSB = 8;
  localparam int LOG_Q_MSB = 7;
  localparam int LOG_Q_LSB = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARM,
    S_CAPTURE,
    S_FULL,
    S_RDREQ,
    S_SETTLE,
    S_ADDR,
    S_OUT,
    S_DONE
  } log_state_e;

endpackage

// File: rtl/log_dump_ctrl_if.sv
// Dump output stream: registered data with valid/ready handshake and a
// last flag on the final word of a dump.
interface log_stream_if #(
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/log_dump_ctrl_wdog.sv
// Capture timeout counter. Counts cycles while enabled and flags expiry on
// the CYCLES-th enabled cycle; clears as soon as the enable drops.
module log_wdog #(
  parameter int CYCLES = 40
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_expire
);
  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] cnt;

  assign o_expire = i_en && (cnt == W'(CYCLES - 1));

  // Cycle counter, held at zero outside the watched window
  always_ff @(posedge clk) begin
    if (i_rst)          cnt <= '0;
    else if (!i_en)     cnt <= '0;
    else if (!o_expire) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/log_dump_ctrl.sv
// Sample logger dump sequencer. Arms a capture on host command, waits for
// the logger full flag, then sweeps the read address and streams every
// stored I/Q word on a valid/ready interface.
// Optional build macro: LOG_WDOG_EN adds a capture timeout that drives o_err.
module log_dump_ctrl
  import log_ctrl_pkg::*;
#(
  parameter int ADDR_W      = LOG_ADDR_W,
  parameter int DATA_W      = LOG_DATA_W,
  parameter int RD_LATENCY  = 1,
  parameter int N_WORDS     = 2**ADDR_W,
  parameter int WDOG_CYCLES = 2**(ADDR_W+1)
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_dump,
  input  logic              i_abort,
  output logic              o_run_log,
  output logic              o_read_log,
  output logic [ADDR_W-1:0] o_addr_log_to_mem,
  input  logic              i_mem_full,
  input  logic [DATA_W-1:0] i_data_log_from_mem,
  log_stream_if.master      strm,
  output logic              o_busy,
  output logic              o_err
);
  localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LATENCY - 1);

  log_state_e        state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              blank;
  logic              wdog_exp;
  logic              start_ok;
  logic              cnt_last;
  logic              lat_done;
  logic              rd_active;

  assign cnt_last  = (cnt == LAST_ADDR);
  assign lat_done  = (lat_cnt == LAT_LAST);
  assign start_ok  = i_start && (state == S_IDLE || state == S_FULL || state == S_DONE);
  assign rd_active = (state == S_RDREQ || state == S_SETTLE || state == S_ADDR || state == S_OUT);

  assign o_addr_log_to_mem = cnt;
  assign strm.last         = strm.valid && cnt_last;
  assign o_busy            = !(state == S_IDLE || state == S_FULL || state == S_DONE);

`ifdef LOG_WDOG_EN
  log_wdog #(.CYCLES(WDOG_CYCLES)) u_wdog (
    .clk      (clk),
    .i_rst    (i_rst),
    .i_en     (state == S_CAPTURE),
    .o_expire (wdog_exp)
  );

  // Sticky timeout flag; a fresh capture command clears it
  always_ff @(posedge clk) begin
    if (i_rst)                                      o_err <= 1'b0;
    else if (start_ok)                              o_err <= 1'b0;
    else if (state == S_CAPTURE && state_nx == S_IDLE) o_err <= 1'b1;
  end
`else
  assign wdog_exp = 1'b0;
  assign o_err    = 1'b0;
`endif

  // Next-state decode; abort wins over a handshake while reading out
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (i_start) state_nx = S_ARM;
      S_ARM:     state_nx = S_CAPTURE;
      S_CAPTURE: begin
        if (!blank && i_mem_full) state_nx = S_FULL;
        else if (wdog_exp)        state_nx = S_IDLE;
      end
      S_FULL, S_DONE: begin
        if (i_start)     state_nx = S_ARM;
        else if (i_dump) state_nx = S_RDREQ;
      end
      S_RDREQ:   state_nx = S_SETTLE;
      S_SETTLE:  state_nx = S_ADDR;
      S_ADDR:    if (lat_done) state_nx = S_OUT;
      S_OUT:     if (strm.ready) state_nx = cnt_last ? S_DONE : S_ADDR;
      default:   state_nx = S_IDLE;
    endcase
    if (rd_active && i_abort) state_nx = S_FULL;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lat_cnt    <= '0;
      blank      <= 1'b0;
      o_run_log  <= 1'b0;
      o_read_log <= 1'b0;
      strm.valid <= 1'b0;
      strm.data  <= '0;
    end else begin
      state      <= state_nx;
      o_run_log  <= (state_nx == S_ARM);
      o_read_log <= (state_nx == S_RDREQ);
      strm.valid <= (state_nx == S_OUT);
      // first CAPTURE cycle ignores a stale full flag from the last capture
      blank      <= (state != S_CAPTURE) && (state_nx == S_CAPTURE);

      if (state == S_RDREQ)                        cnt <= '0;
      else if (state == S_OUT && state_nx == S_ADDR) cnt <= cnt + ADDR_W'(1);

      if (state != S_ADDR) lat_cnt <= '0;
      else if (!lat_done)  lat_cnt <= lat_cnt + LAT_W'(1);

      if (state == S_ADDR && state_nx == S_OUT) strm.data <= i_data_log_from_mem;
    end
  end
endmodule

// File: tb/tb_log_dump_ctrl.sv
// Bench for log_dump_ctrl: behavioural logger memory, scoreboard of expected
// stream words built from memory contents, independent negedge monitor.
module tb_log_dump_ctrl;
  import log_ctrl_pkg::*;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int NW = 16;
  localparam int RL = 1;
  localparam int WD = 40;

  logic          clk = 1'b0;
  logic          i_rst, i_start, i_dump, i_abort, i_mem_full;
  logic          o_run_log, o_read_log, o_busy, o_err;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] i_data;
  logic [DW-1:0] mem [NW];

  log_stream_if #(.DATA_W(DW)) strm ();

  always #5 clk = ~clk;

  log_dump_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RL), .N_WORDS(NW), .WDOG_CYCLES(WD)
  ) dut (
    .clk                 (clk),
    .i_rst               (i_rst),
    .i_start             (i_start),
    .i_dump              (i_dump),
    .i_abort             (i_abort),
    .o_run_log           (o_run_log),
    .o_read_log          (o_read_log),
    .o_addr_log_to_mem   (o_addr),
    .i_mem_full          (i_mem_full),
    .i_data_log_from_mem (i_data),
    .strm                (strm),
    .o_busy              (o_busy),
    .o_err               (o_err)
  );

  // Behavioural logger read port: data follows the address within a cycle
  assign i_data = mem[o_addr];

  typedef struct {
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic          l;
  } exp_t;

  exp_t exp_q[$];
  int   hs_t[$];
  int   hs_cnt = 0;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic          pv = 1'b0, pr = 1'b0, pa = 1'b0;
  logic [DW-1:0] pd = '0;
  logic [AW-1:0] pad = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: stall stability, handshake scoreboard, last/valid consistency
  always @(negedge clk) begin
    if (!i_rst) begin
      if (pv && !pr && !pa) begin
        chk("stall_valid", 32'(strm.valid), 32'd1);
        chk("stall_data", 32'(strm.data), 32'(pd));
        chk("stall_addr", 32'(o_addr), 32'(pad));
      end
      if (strm.valid && strm.ready && !i_abort) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(strm.data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word_data", 32'(strm.data), 32'(e.d));
          chk("word_addr", 32'(o_addr), 32'(e.a));
          chk("word_last", 32'(strm.last), 32'(e.l));
        end
        hs_cnt <= hs_cnt + 1;
        hs_t.push_back(cyc);
      end
      if (strm.last && !strm.valid) chk("last_without_valid", 32'd1, 32'd0);
      if (o_run_log && o_read_log)  chk("run_and_read", 32'd1, 32'd0);
    end
    pv  <= strm.valid;
    pr  <= strm.ready;
    pa  <= i_abort;
    pd  <= strm.data;
    pad <= o_addr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expect();
    for (int k = 0; k < NW; k++) begin
      exp_t e;
      e.d = mem[k];
      e.a = AW'(k);
      e.l = (k == NW - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic fill_seq();
    for (int k = 0; k < NW; k++) mem[k] = DW'(16'h0100 + k);
  endtask

  // Full readout from FULL/DONE; rnd selects a randomly stalling sink
  task automatic do_dump(input bit rnd);
    int base;
    bit done;
    base = hs_cnt;
    hs_t.delete();
    push_expect();
    strm.ready = 1'b1;
    i_dump = 1'b1;
    tick();
    i_dump = 1'b0;
    chk("dump_read_pulse", 32'(o_read_log), 32'd1);
    chk("dump_no_run", 32'(o_run_log), 32'd0);
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (rnd) strm.ready = 1'($urandom_range(0, 1));
      tick();
      if (exp_q.size() == 0 && !o_busy) done = 1'b1;
    end
    strm.ready = 1'b1;
    chk("dump_done", 32'(done), 32'd1);
    chk("dump_count", 32'(hs_cnt - base), 32'(NW));
    chk("dump_valid_off", 32'(strm.valid), 32'd0);
    if (!rnd && hs_t.size() == NW)
      for (int i = 1; i < NW; i++)
        chk("dump_spacing", 32'(hs_t[i] - hs_t[i-1]), 32'(RL + 1));
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit hit;
    i_rst = 1'b1; i_start = 1'b0; i_dump = 1'b0; i_abort = 1'b0; i_mem_full = 1'b0;
    strm.ready = 1'b0;
    fill_seq();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_run", 32'(o_run_log), 32'd0);
    chk("rst_read", 32'(o_read_log), 32'd0);
    chk("rst_valid", 32'(strm.valid), 32'd0);
    chk("rst_last", 32'(strm.last), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_addr", 32'(o_addr), 32'd0);
    chk("rst_data", 32'(strm.data), 32'd0);
    i_rst = 1'b0;
    tick();

    // capture: run pulse one cycle after start, abort ignored while capturing
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("arm_run_pulse", 32'(o_run_log), 32'd1);
    chk("arm_busy", 32'(o_busy), 32'd1);
    tick();
    chk("capture_run_off", 32'(o_run_log), 32'd0);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    repeat (3) tick();
    chk("capture_abort_ignored", 32'(o_busy), 32'd1);
    i_mem_full = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 5 && !hit; i++) begin
      tick();
      if (!o_busy) hit = 1'b1;
    end
    chk("full_reached", 32'(hit), 32'd1);
    chk("full_no_read", 32'(o_read_log), 32'd0);

    // sequential pattern with ready held high
    fill_seq();
    do_dump(1'b0);

    // random contents, randomly stalling sink (re-dump from DONE)
    for (int k = 0; k < NW; k++) mem[k] = DW'($urandom);
    do_dump(1'b1);

    // abort on the fifth word while it is presented
    fill_seq();
    push_expect();
    hit = 1'b0;
    begin
      int base;
      base = hs_cnt;
      strm.ready = 1'b1;
      i_dump = 1'b1;
      tick();
      i_dump = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
        tick();
        if (hs_cnt - base == 4) hit = 1'b1;
      end
    end
    strm.ready = 1'b0;
    chk("abort_four_words", 32'(hit), 32'd1);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (strm.valid) hit = 1'b1;
      else tick();
    end
    chk("abort_word_valid", 32'(hit), 32'd1);
    chk("abort_word_data", 32'(strm.data), 32'h0104);
    chk("abort_word_addr", 32'(o_addr), 32'd4);
    i_abort = 1'b1;
    strm.ready = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("abort_valid_off", 32'(strm.valid), 32'd0);
    chk("abort_no_last", 32'(strm.last), 32'd0);
    chk("abort_to_full", 32'(o_busy), 32'd0);
    chk("abort_remaining", 32'(exp_q.size()), 32'(NW - 4));
    exp_q.delete();
    tick();
    do_dump(1'b0);

    // start and dump together in DONE: start wins; blanking cycle ignores full
    i_start = 1'b1;
    i_dump  = 1'b1;
    tick();
    i_start = 1'b0;
    i_dump  = 1'b0;
    chk("prio_run", 32'(o_run_log), 32'd1);
    chk("prio_no_read", 32'(o_read_log), 32'd0);
    tick();
    chk("blank_busy1", 32'(o_busy), 32'd1);
    chk("blank_no_read", 32'(o_read_log), 32'd0);
    tick();
    chk("blank_busy2", 32'(o_busy), 32'd1);
    tick();
    chk("blank_then_full", 32'(o_busy), 32'd0);
    chk("prio_valid_off", 32'(strm.valid), 32'd0);

`ifdef LOG_WDOG_EN
    // capture timeout after WD cycles without full
    i_mem_full = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (WD) tick();
    chk("wdog_pre_err", 32'(o_err), 32'd0);
    chk("wdog_pre_busy", 32'(o_busy), 32'd1);
    tick();
    chk("wdog_err", 32'(o_err), 32'd1);
    chk("wdog_idle", 32'(o_busy), 32'd0);
    repeat (3) tick();
    chk("wdog_err_sticky", 32'(o_err), 32'd1);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("wdog_err_clear", 32'(o_err), 32'd0);
    chk("wdog_rearm", 32'(o_run_log), 32'd1);
`else
    chk("err_tied_low", 32'(o_err), 32'd0);
`endif

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
